// File: rtl/thermostat_if.sv
// Sensor/user inputs and actuator drives shared by the thermostat and its
// environment.
interface thermostat_if;
   logic too_cold;
   logic too_hot;
   logic mode;
   logic fan_on;
   logic heater;
   logic aircon;
   logic fan;

   modport master (
      output too_cold, too_hot, mode, fan_on,
      input  heater, aircon, fan
   );

   modport slave (
      input  too_cold, too_hot, mode, fan_on,
      output heater, aircon, fan
   );
endinterface

// File: rtl/thermostat.sv
// HVAC thermostat controller.
// Converts room-sensor flags, a heat/cool mode select and a manual fan request
// into registered heater, air-conditioner and blower drives. The compressor
// has an optional anti-short-cycle lockout. The blower has an optional run-on
// after either device stops.
module thermostat #(
   parameter int unsigned MIN_OFF_CYCLES   = 0,
   parameter int unsigned FAN_RUNON_CYCLES = 0
) (
   input  logic         clk_i,
   input  logic         reset_i,
   thermostat_if.slave  th
);

   localparam int unsigned LOCK_W  = (MIN_OFF_CYCLES   > 0) ? $clog2(MIN_OFF_CYCLES + 1)   : 1;
   localparam int unsigned RUNON_W = (FAN_RUNON_CYCLES > 0) ? $clog2(FAN_RUNON_CYCLES + 1) : 1;

   localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(MIN_OFF_CYCLES);
   localparam logic [RUNON_W-1:0] RUNON_LOAD = RUNON_W'(FAN_RUNON_CYCLES);

   logic               heater_q, heater_d;
   logic               aircon_q, aircon_d;
   logic               fan_q,    fan_d;
   logic [LOCK_W-1:0]  lock_q,   lock_d;
   logic [RUNON_W-1:0] runon_q,  runon_d;

   logic heat_req;
   logic cool_req;
   logic aircon_fall;
   logic demand_fall;

   // Demand terms. Mode picks exactly one, so heater and aircon are never both on.
   assign heat_req = th.mode & th.too_cold;
   assign cool_req = ~th.mode & th.too_hot;

   // Next-state logic for the drives and the two down-counters.
   always_comb begin
      heater_d    = heat_req;
      aircon_d    = cool_req & (lock_q == '0);
      aircon_fall = aircon_q & ~aircon_d;
      demand_fall = (heater_q & ~heater_d) | aircon_fall;

      // The lockout counter is armed on the compressor's falling edge.
      // It holds aircon off until it reaches zero.
      lock_d = lock_q;
      if (aircon_fall) begin
         lock_d = LOCK_LOAD;
      end else if (lock_q != '0) begin
         lock_d = lock_q - 1'b1;
      end

      // The run-on counter covers the cycles right after a demand output drops.
      // A new drop reloads it.
      runon_d = runon_q;
      if (demand_fall) begin
         runon_d = RUNON_LOAD;
      end else if (runon_q != '0) begin
         runon_d = runon_q - 1'b1;
      end

      fan_d = th.fan_on | heater_d | aircon_d | (runon_d != '0);
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         heater_q <= 1'b0;
         aircon_q <= 1'b0;
         fan_q    <= 1'b0;
         lock_q   <= '0;
         runon_q  <= '0;
      end else begin
         heater_q <= heater_d;
         aircon_q <= aircon_d;
         fan_q    <= fan_d;
         lock_q   <= lock_d;
         runon_q  <= runon_d;
      end
   end

   assign th.heater = heater_q;
   assign th.aircon = aircon_q;
   assign th.fan    = fan_q;

endmodule

// File: tb/tb_thermostat.sv
// Directed testbench for the thermostat.
// Three instances are built: defaults, lockout of 3, and fan run-on of 2.
// All three share the same clock, reset and input vectors.
module tb_thermostat;

   logic clk_i = 1'b0;
   logic reset_i;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   thermostat_if if_def ();
   thermostat_if if_lck ();
   thermostat_if if_run ();

   thermostat #(.MIN_OFF_CYCLES(0), .FAN_RUNON_CYCLES(0)) dut_def (
      .clk_i(clk_i), .reset_i(reset_i), .th(if_def.slave));
   thermostat #(.MIN_OFF_CYCLES(3), .FAN_RUNON_CYCLES(0)) dut_lck (
      .clk_i(clk_i), .reset_i(reset_i), .th(if_lck.slave));
   thermostat #(.MIN_OFF_CYCLES(0), .FAN_RUNON_CYCLES(2)) dut_run (
      .clk_i(clk_i), .reset_i(reset_i), .th(if_run.slave));

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Apply {mode, too_hot, too_cold, fan_on} to all three instances.
   task automatic drive(input logic [3:0] v);
      if_def.mode = v[3]; if_def.too_hot = v[2]; if_def.too_cold = v[1]; if_def.fan_on = v[0];
      if_lck.mode = v[3]; if_lck.too_hot = v[2]; if_lck.too_cold = v[1]; if_lck.fan_on = v[0];
      if_run.mode = v[3]; if_run.too_hot = v[2]; if_run.too_cold = v[1]; if_run.fan_on = v[0];
   endtask

   // Advance one edge and settle just after it, so outputs are read away from the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
   endtask

   // Expected default-instance outputs for a sweep vector {heater, aircon, fan}.
   function automatic logic [2:0] exp_tt(input logic [3:0] v);
      logic h, a;
      h = v[3] & v[1];
      a = ~v[3] & v[2];
      return {h, a, h | a | v[0]};
   endfunction

   initial begin
      logic [2:0] e;
      reset_i = 1'b0;
      drive(4'b0000);
      do_reset();
      chk("rst_heater", if_def.heater, 1'b0);
      chk("rst_aircon", if_def.aircon, 1'b0);
      chk("rst_fan",    if_def.fan,    1'b0);
      chk("rst_run_fan", if_run.fan,   1'b0);

      // Truth-table sweep on the default instance.
      for (int v = 0; v < 16; v++) begin
         drive(4'(v));
         step();
         step();
         e = exp_tt(4'(v));
         chk($sformatf("sweep%0d_heater", v), if_def.heater, e[2]);
         chk($sformatf("sweep%0d_aircon", v), if_def.aircon, e[1]);
         chk($sformatf("sweep%0d_fan",    v), if_def.fan,    e[0]);
      end

      // Spot vectors with hand-written results.
      drive(4'b0100); step();
      chk("v4_aircon", if_def.aircon, 1'b1); chk("v4_fan", if_def.fan, 1'b1); chk("v4_heater", if_def.heater, 1'b0);
      drive(4'b1010); step();
      chk("v10_heater", if_def.heater, 1'b1); chk("v10_fan", if_def.fan, 1'b1); chk("v10_aircon", if_def.aircon, 1'b0);
      drive(4'b0001); step();
      chk("v1_fan", if_def.fan, 1'b1); chk("v1_heater", if_def.heater, 1'b0); chk("v1_aircon", if_def.aircon, 1'b0);
      drive(4'b1100); step();
      chk("v12_fan", if_def.fan, 1'b0); chk("v12_heater", if_def.heater, 1'b0); chk("v12_aircon", if_def.aircon, 1'b0);
      drive(4'b0110); step();
      chk("v6_aircon", if_def.aircon, 1'b1); chk("v6_heater", if_def.heater, 1'b0);

      // Reset mid-operation.
      drive(4'b1010); step();
      chk("rmid_pre_heater", if_def.heater, 1'b1);
      reset_i = 1'b1; step();
      chk("rmid_heater", if_def.heater, 1'b0);
      chk("rmid_fan",    if_def.fan,    1'b0);
      reset_i = 1'b0; step();
      chk("rmid_post_heater", if_def.heater, 1'b1);

      // Compressor lockout, 3 cycles.
      drive(4'b0000); do_reset();
      drive(4'b0100); step();
      chk("lck_on", if_lck.aircon, 1'b1);
      drive(4'b0000); step();
      chk("lck_fall", if_lck.aircon, 1'b0);
      chk("lck_fall_fan", if_lck.fan, 1'b0);
      drive(4'b0100); step();
      chk("lck_hold1", if_lck.aircon, 1'b0);
      chk("nolck_back", if_def.aircon, 1'b1);
      step();
      chk("lck_hold2", if_lck.aircon, 1'b0);
      step();
      chk("lck_hold3", if_lck.aircon, 1'b0);
      step();
      chk("lck_release", if_lck.aircon, 1'b1);

      // Fan run-on, 2 cycles, after the heater stops.
      drive(4'b0000); do_reset();
      drive(4'b1010); step();
      chk("run_heater", if_run.heater, 1'b1);
      drive(4'b1000); step();
      chk("run_heater_off", if_run.heater, 1'b0);
      chk("run_fan1", if_run.fan, 1'b1);
      chk("norun_fan", if_def.fan, 1'b0);
      step();
      chk("run_fan2", if_run.fan, 1'b1);
      step();
      chk("run_fan_end", if_run.fan, 1'b0);

      // A second drop during run-on restarts the count.
      drive(4'b1010); step();
      drive(4'b1000); step();
      drive(4'b1010); step();
      drive(4'b1000); step();
      chk("restart_fan1", if_run.fan, 1'b1);
      step();
      chk("restart_fan2", if_run.fan, 1'b1);
      step();
      chk("restart_end", if_run.fan, 1'b0);

      // Mode flip while cooling with both sensor flags set.
      drive(4'b0000); do_reset();
      drive(4'b0110); step();
      chk("flip_pre_aircon", if_def.aircon, 1'b1);
      chk("flip_pre_heater", if_def.heater, 1'b0);
      drive(4'b1110); step();
      chk("flip_aircon", if_def.aircon, 1'b0);
      chk("flip_heater", if_def.heater, 1'b1);
      chk("flip_fan",    if_def.fan,    1'b1);
      chk("flip_run_fan", if_run.fan,   1'b1);
      step();
      chk("flip_fan_hold", if_def.fan, 1'b1);

      // Manual fan request held across run-on expiry.
      drive(4'b0000); do_reset();
      drive(4'b1010); step();
      drive(4'b1000); step();
      chk("ovr_runon", if_run.fan, 1'b1);
      drive(4'b1001); step();
      step();
      step();
      chk("ovr_past_expiry", if_run.fan, 1'b1);
      drive(4'b1000); step();
      chk("ovr_release", if_run.fan, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/thermostat.md
# thermostat

Synchronous HVAC thermostat controller. It turns room-sensor flags (`too_cold`, `too_hot`), a heat/cool mode select and a manual fan request into registered drive signals for the heater, air conditioner and blower fan. It includes optional compressor anti-short-cycle lockout and optional fan run-on. It sits between the sensor/user-input logic and the actuator drivers.

## Interface
Parameters:
- `MIN_OFF_CYCLES`, default 0: minimum extra off-time for `aircon` after it deasserts; 0 disables the lockout.
- `FAN_RUNON_CYCLES`, default 0: cycles the fan keeps running after `heater`/`aircon` deasserts; 0 disables run-on.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: reset is synchronous and active-high.
- `too_cold`, in, 1: room below setpoint.
- `too_hot`, in, 1: room above setpoint.
- `mode`, in, 1: 1 = heating mode, 0 = cooling mode.
- `fan_on`, in, 1: user manual fan request.
- `heater`, out, 1: heater drive (registered).
- `aircon`, out, 1: air-conditioner drive (registered).
- `fan`, out, 1: blower drive (registered).

## Operation
- Demand terms (combinational):
  - `heat_req = mode & too_cold`
  - `cool_req = ~mode & too_hot`
- `heater` next value = `heat_req`.
- `aircon` next value = `cool_req & (lock_cnt == 0)`.
- Lockout counter `lock_cnt`:
  - Width `$clog2(MIN_OFF_CYCLES+1)`, minimum 1 bit.
  - Loads `MIN_OFF_CYCLES` on the edge where `aircon` goes 1→0.
  - Otherwise decrements while nonzero and saturates at 0.
- Fan run-on:
  - When `heater` or `aircon` deasserts, `fan` stays 1 for exactly `FAN_RUNON_CYCLES` cycles, starting with the cycle in which the demand output first reads 0.
  - A new deassertion during run-on restarts the count.
- `fan` = 1 whenever any of these holds in the same cycle: `fan_on` (registered), `heater`, `aircon`, or run-on active.
- `heater` and `aircon` are never 1 simultaneously, because `mode` selects exactly one demand.
- `too_cold` and `too_hot` both 1: only the demand matching `mode` acts. No error flag.
- Mode change while a device runs: that device drops on the next edge. Lockout and run-on apply normally.
- The heater has no lockout.

## Timing
- Latency is 1 clock from any input change to the corresponding output change. There are no combinational input→output paths.
- Reset state (edge with `reset`=1):
  - `heater`, `aircon` and `fan` all = 0.
  - `lock_cnt` and the run-on counter = 0.
  - Reset does not arm the lockout or run-on.
- Reset mid-operation clears everything on that edge. The first post-reset edge evaluates inputs normally.
- Lockout timing: with `MIN_OFF_CYCLES`=N, `aircon` remains 0 for at least N+1 cycles after falling, even if `cool_req` returns immediately.
- With both parameters 0, outputs follow this registered truth table:
  - heater = mode·too_cold
  - aircon = ~mode·too_hot
  - fan = heater | aircon | fan_on

## Test plan
- Defaults, reset, then sweep {`mode`,`too_hot`,`too_cold`,`fan_on`} = 0..15, holding each value for 2 cycles. Required outputs one cycle later:
  - 0b0100 → aircon=1, fan=1, heater=0
  - 0b1010 → heater=1, fan=1, aircon=0
  - 0b0001 → fan=1 only
  - 0b1100 → all 0
  - 0b0110 → aircon=1
- Reset behaviour: drive `mode`=1, `too_cold`=1 to get heater=1, then assert `reset` for 1 cycle → all outputs 0 on that edge; heater=1 again one edge after `reset` drops.
- Lockout with `MIN_OFF_CYCLES`=3: `mode`=0, `too_hot`=1 so aircon=1. Pulse `too_hot` low for 1 cycle, then high → aircon stays 0 for 4 cycles, then returns to 1.
- Run-on with `FAN_RUNON_CYCLES`=2, `fan_on`=0: heater=1, then `too_cold`→0 → heater=0 next edge; fan stays 1 for 2 more cycles, then 0.
- Mode flip while cooling: `too_hot`=`too_cold`=1, `mode` 0→1 → next edge aircon=0, heater=1, fan=1 continuously.
- Run-on override: during run-on, `fan_on`=1 keeps fan=1 past expiry; `fan_on`=0 after expiry → fan=0 next edge.
